mem_request_sequencer: RTL and testbench

Core-side initiator for the N-core memory controller's MRead/MWrite/MReady handshake. It accepts one load or store per instruction from the SIMT execute stage and latches the per-core enable, address and data vectors. It issues a one-cycle MRead/MWrite pulse, holds the vectors stable until the controller reports MReady, then captures the per-core read data and presents it to register writeback. It stalls the pipeline for the whole transaction.

---
 rtl/mem_request_sequencer_pkg.sv | 16 +
 rtl/mem_request_sequencer_if.sv | 35 +++
 rtl/mem_request_sequencer.sv | 127 ++++++++++++
 tb/tb_mem_request_sequencer.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_request_sequencer_pkg.sv
// Shared constants for the memory request sequencer: core count, data width, clock period,
// transaction timeout and the 3-bit FSM state encodings.
package mem_request_sequencer_pkg;
    localparam int N_CORES_LOG    = 2;
    localparam int N_CORES        = 1 << N_CORES_LOG;
    localparam int DW             = 16;
    localparam int RD_W           = 4;
    localparam int CLK_PERIOD     = 10;
    localparam int TIMEOUT_CYCLES = 1024;

    localparam logic [2:0] MRS_IDLE      = 3'd0;
    localparam logic [2:0] MRS_ISSUE     = 3'd1;
    localparam logic [2:0] MRS_WAIT_BUSY = 3'd2;
    localparam logic [2:0] MRS_WAIT_DONE = 3'd3;
    localparam logic [2:0] MRS_WB        = 3'd4;
endpackage

// File: rtl/mem_request_sequencer_if.sv
// Pipeline-side op/writeback signals plus the MRead/MWrite/MReady controller port.
// master = the sequencer, slave = execute stage + memory controller side.
interface mem_request_sequencer_if;
    import mem_request_sequencer_pkg::*;

    logic                    op_valid;
    logic                    op_write;
    logic [N_CORES-1:0]      op_en;
    logic [N_CORES*DW-1:0]   op_addr;
    logic [N_CORES*DW-1:0]   op_data;
    logic [RD_W-1:0]         op_rd;
    logic                    stall;
    logic                    wb_valid;
    logic [N_CORES-1:0]      wb_en;
    logic [N_CORES*DW-1:0]   wb_data;
    logic [RD_W-1:0]         wb_rd;
    logic                    MRead;
    logic                    MWrite;
    logic                    MReady;
    logic [N_CORES-1:0]      en;
    logic [N_CORES*DW-1:0]   addr;
    logic [N_CORES*DW-1:0]   data;
    logic [N_CORES*DW-1:0]   q;
    logic                    timeout_err;

    modport master (
        input  op_valid, op_write, op_en, op_addr, op_data, op_rd, MReady, q,
        output stall, wb_valid, wb_en, wb_data, wb_rd, MRead, MWrite, en, addr, data, timeout_err
    );

    modport slave (
        output op_valid, op_write, op_en, op_addr, op_data, op_rd, MReady, q,
        input  stall, wb_valid, wb_en, wb_data, wb_rd, MRead, MWrite, en, addr, data, timeout_err
    );
endinterface

// File: rtl/mem_request_sequencer.sv
// Core-side MRead/MWrite/MReady initiator; latches one op, pulses the request, writes back loads.
// Latency: request 1 cycle after accept, writeback 1 cycle after MReady rises; stall held for the whole transaction.
// MEM_TIMEOUT_EN: abort a stuck transaction after TIMEOUT_CYCLES and raise sticky timeout_err.
module mem_request_sequencer
    import mem_request_sequencer_pkg::*;
(
    input  logic                    clk,
    input  logic                    reset,
    mem_request_sequencer_if.master bus
);
    localparam int W = N_CORES * DW;

    logic [2:0]         state;
    logic               wr_flag;
    logic               rdy_seen;
    logic [N_CORES-1:0] en_r;
    logic [W-1:0]       addr_r;
    logic [W-1:0]       data_r;
    logic [RD_W-1:0]    rd_r;
    logic [N_CORES-1:0] wb_en_r;
    logic [W-1:0]       wb_data_r;
    logic [W-1:0]       q_masked;
    logic               to_hit;
    logic               done_now;

`ifdef MEM_TIMEOUT_EN
    logic        waiting;
    logic [15:0] to_cnt;
    logic        to_err;

    // Counter spans WAIT_BUSY and WAIT_DONE so a controller stuck at either phase is caught.
    assign waiting = (state == MRS_WAIT_BUSY) || (state == MRS_WAIT_DONE);
    assign to_hit  = waiting && (to_cnt == 16'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            to_cnt <= '0;
            to_err <= 1'b0;
        end else begin
            to_cnt <= (waiting && !to_hit) ? to_cnt + 16'd1 : 16'd0;
            if (to_hit)
                to_err <= 1'b1;
        end
    end

    assign bus.timeout_err = to_err;
`else
    assign to_hit          = 1'b0;
    assign bus.timeout_err = 1'b0;
`endif

    always_comb begin
        q_masked = '0;
        for (int i = 0; i < N_CORES; i++)
            if (en_r[i])
                q_masked[i*DW +: DW] = bus.q[i*DW +: DW];
    end

    // Two consecutive MReady=1 cycles in WAIT_BUSY means the controller finished without ever going busy.
    assign done_now = !to_hit &&
                      (((state == MRS_WAIT_BUSY) && bus.MReady && rdy_seen) ||
                       ((state == MRS_WAIT_DONE) && bus.MReady));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= MRS_IDLE;
            wr_flag   <= 1'b0;
            rdy_seen  <= 1'b0;
            en_r      <= '0;
            addr_r    <= '0;
            data_r    <= '0;
            rd_r      <= '0;
            wb_en_r   <= '0;
            wb_data_r <= '0;
        end else begin
            if (done_now && !wr_flag) begin
                wb_data_r <= q_masked;
                wb_en_r   <= en_r;
            end
            case (state)
                MRS_IDLE: begin
                    if (bus.op_valid) begin
                        en_r    <= bus.op_en;
                        addr_r  <= bus.op_addr;
                        data_r  <= bus.op_data;
                        rd_r    <= bus.op_rd;
                        wr_flag <= bus.op_write;
                        state   <= (|bus.op_en) ? MRS_ISSUE : MRS_IDLE;
                    end
                end
                MRS_ISSUE: begin
                    rdy_seen <= 1'b0;
                    state    <= MRS_WAIT_BUSY;
                end
                MRS_WAIT_BUSY: begin
                    if (to_hit)
                        state <= MRS_IDLE;
                    else if (!bus.MReady)
                        state <= MRS_WAIT_DONE;
                    else if (rdy_seen)
                        state <= wr_flag ? MRS_IDLE : MRS_WB;
                    else
                        rdy_seen <= 1'b1;
                end
                MRS_WAIT_DONE: begin
                    if (to_hit)
                        state <= MRS_IDLE;
                    else if (bus.MReady)
                        state <= wr_flag ? MRS_IDLE : MRS_WB;
                end
                MRS_WB:  state <= MRS_IDLE;
                default: state <= MRS_IDLE;
            endcase
        end
    end

    assign bus.stall    = (state == MRS_IDLE) ? bus.op_valid : 1'b1;
    assign bus.MRead    = (state == MRS_ISSUE) && !wr_flag;
    assign bus.MWrite   = (state == MRS_ISSUE) && wr_flag;
    assign bus.wb_valid = (state == MRS_WB);
    assign bus.wb_en    = wb_en_r;
    assign bus.wb_data  = wb_data_r;
    assign bus.wb_rd    = rd_r;
    assign bus.en       = en_r;
    assign bus.addr     = addr_r;
    assign bus.data     = data_r;
endmodule

// File: tb/tb_mem_request_sequencer.sv
// Bench for mem_request_sequencer: directed and random ops against a memory-array reference model,
// with a behavioural controller and a scoreboard monitor checking requests and writebacks.
module tb_mem_request_sequencer;
    import mem_request_sequencer_pkg::*;
    localparam int W = N_CORES * DW;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #(CLK_PERIOD/2) clk = ~clk;

    mem_request_sequencer_if bus();
    mem_request_sequencer dut (.clk(clk), .reset(reset), .bus(bus));

    typedef struct {
        logic               wr;
        logic [N_CORES-1:0] en;
        logic [W-1:0]       addr;
        logic [W-1:0]       data;
    } req_t;
    typedef struct {
        logic [N_CORES-1:0] en;
        logic [W-1:0]       data;
        logic [RD_W-1:0]    rd;
    } wb_t;

    req_t req_q[$];
    wb_t  wb_q[$];
    int   total = 0;
    int   bad = 0;
    int   exp_loads = 0, exp_stores = 0;
    int   mread_cnt = 0, mwrite_cnt = 0;
    logic [DW-1:0] ref_mem [0:255];
    logic [DW-1:0] ctl_mem [0:255];

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    function automatic logic [W-1:0] mk_addr(input int base, input int stride);
        logic [W-1:0] a;
        a = '0;
        for (int i = 0; i < N_CORES; i++) a[i*DW +: DW] = DW'(base + i*stride);
        return a;
    endfunction

    function automatic logic [W-1:0] rand_w();
        logic [W-1:0] d;
        d = '0;
        for (int i = 0; i < N_CORES; i++) d[i*DW +: DW] = DW'($urandom);
        return d;
    endfunction

    // ---------------- memory controller model ----------------
    int                 force_mode = 0;
    int                 busy_left = 0;
    logic               cur_wr;
    logic [N_CORES-1:0] cur_en;
    logic [W-1:0]       cur_addr, cur_data;

    task automatic ctl_complete(input bit chk_hold);
        int a;
        if (chk_hold) begin
            check("hold_en", W'(bus.en), W'(cur_en));
            check("hold_addr", bus.addr, cur_addr);
            check("hold_data", bus.data, cur_data);
        end
        for (int i = 0; i < N_CORES; i++) begin
            a = int'(cur_addr[i*DW +: DW]) & 255;
            if (cur_wr && cur_en[i]) ctl_mem[a] = cur_data[i*DW +: DW];
            bus.q[i*DW +: DW] = cur_en[i] ? ctl_mem[a] : DW'($urandom);
        end
    endtask

    initial begin
        int mode;
        bus.MReady = 1'b1;
        bus.q = '0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                bus.MReady = 1'b1;
                busy_left = 0;
            end else if (busy_left > 0) begin
                busy_left--;
                if (busy_left == 0) begin
                    ctl_complete(1'b1);
                    bus.MReady = 1'b1;
                end
            end else if (bus.MRead || bus.MWrite) begin
                cur_wr = bus.MWrite; cur_en = bus.en; cur_addr = bus.addr; cur_data = bus.data;
                mode = (force_mode == 0) ? int'($urandom_range(1, 2)) : force_mode;
                if (mode == 1) ctl_complete(1'b0);
                else begin
                    bus.MReady = 1'b0;
                    busy_left = (mode == 2) ? int'($urandom_range(1, 5)) : ((mode == 3) ? 8 : 3000);
                end
            end
        end
    end

    // ---------------- scoreboard monitor ----------------
    req_t mr;
    wb_t  mw;
    logic load_open = 1'b0;
    logic prev_wb = 1'b0;

    always @(negedge clk) begin
        if (!reset) begin
            load_open = 1'b0;
            prev_wb = 1'b0;
        end else begin
            if (prev_wb) check("stall_after_wb", W'(bus.stall), W'(bus.op_valid));
            prev_wb = bus.wb_valid;
            if (bus.MRead || bus.MWrite) begin
                check("req_exclusive", W'(bus.MRead & bus.MWrite), '0);
                if (bus.MRead) mread_cnt++;
                if (bus.MWrite) mwrite_cnt++;
                check("req_expected", W'(req_q.size() != 0), W'(1));
                if (req_q.size() != 0) begin
                    mr = req_q.pop_front();
                    check("req_kind", W'(bus.MWrite), W'(mr.wr));
                    check("req_en", W'(bus.en), W'(mr.en));
                    check("req_addr", bus.addr, mr.addr);
                    check("req_data", bus.data, mr.data);
                end
                if (bus.MRead) begin
                    check("req_no_overlap", W'(load_open), '0);
                    load_open = 1'b1;
                end
            end
            if (bus.wb_valid) begin
                load_open = 1'b0;
                check("wb_expected", W'(wb_q.size() != 0), W'(1));
                if (wb_q.size() != 0) begin
                    mw = wb_q.pop_front();
                    check("wb_en", W'(bus.wb_en), W'(mw.en));
                    check("wb_data", bus.wb_data, mw.data);
                    check("wb_rd", W'(bus.wb_rd), W'(mw.rd));
                end
                check("wb_stall", W'(bus.stall), W'(1));
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic drive_op(input logic wr, input logic [N_CORES-1:0] en, input logic [W-1:0] addr,
                            input logic [W-1:0] data, input logic [RD_W-1:0] rd);
        req_t r;
        wb_t  w;
        int   a;
        @(posedge clk); #1;
        bus.op_valid = 1'b1; bus.op_write = wr; bus.op_en = en;
        bus.op_addr = addr; bus.op_data = data; bus.op_rd = rd;
        if (en != '0) begin
            r.wr = wr; r.en = en; r.addr = addr; r.data = data;
            req_q.push_back(r);
            w.en = en; w.rd = rd; w.data = '0;
            for (int i = 0; i < N_CORES; i++) begin
                a = int'(addr[i*DW +: DW]) & 255;
                if (en[i] && wr) ref_mem[a] = data[i*DW +: DW];
                if (en[i] && !wr) w.data[i*DW +: DW] = ref_mem[a];
            end
            if (wr) exp_stores++;
            else begin
                exp_loads++;
                wb_q.push_back(w);
            end
        end
    endtask

    task automatic release_op();
        bus.op_valid = 1'b0;
        bus.op_write = 1'($urandom_range(0, 1));
        bus.op_en = N_CORES'($urandom);
        bus.op_addr = rand_w();
        bus.op_data = rand_w();
        bus.op_rd = RD_W'($urandom);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge clk);
        while (bus.stall !== 1'b0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("idle_reached", W'(bus.stall), '0);
    endtask

    task automatic send_op(input logic wr, input logic [N_CORES-1:0] en, input logic [W-1:0] addr,
                           input logic [W-1:0] data, input logic [RD_W-1:0] rd);
        drive_op(wr, en, addr, data, rd);
        @(negedge clk);
        check("stall_on_op", W'(bus.stall), W'(1));
        check("no_req_cycle0", W'(bus.MRead | bus.MWrite), '0);
        @(posedge clk); #1;
        release_op();
        @(negedge clk);
        if (en == '0) check("stall_release", W'(bus.stall), '0);
        else check("req_cycle1", W'(wr ? bus.MWrite : bus.MRead), W'(1));
        wait_idle();
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_stall"}, W'(bus.stall), '0);
        check({tag, "_mread"}, W'(bus.MRead), '0);
        check({tag, "_mwrite"}, W'(bus.MWrite), '0);
        check({tag, "_wb_valid"}, W'(bus.wb_valid), '0);
        check({tag, "_wb_en"}, W'(bus.wb_en), '0);
        check({tag, "_wb_data"}, bus.wb_data, '0);
        check({tag, "_wb_rd"}, W'(bus.wb_rd), '0);
        check({tag, "_en"}, W'(bus.en), '0);
        check({tag, "_addr"}, bus.addr, '0);
        check({tag, "_data"}, bus.data, '0);
        check({tag, "_timeout_err"}, W'(bus.timeout_err), '0);
    endtask

    initial begin
        #(CLK_PERIOD * 60000);
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        bus.op_valid = 1'b0; bus.op_write = 1'b0; bus.op_en = '0;
        bus.op_addr = '0; bus.op_data = '0; bus.op_rd = '0;
        for (int i = 0; i < 256; i++) begin
            ref_mem[i] = '0;
            ctl_mem[i] = '0;
        end
        reset = 1'b0;
        #(3*CLK_PERIOD + 2);
        check_all_zero("reset");
        @(posedge clk); #1;
        reset = 1'b1;

        // Store 9/20/55/24 to 10..13, partial load of lanes 1..3, then full load back.
        send_op(1'b1, 4'b1111, mk_addr(10, 1), {16'd24, 16'd55, 16'd20, 16'd9}, 4'd0);
        send_op(1'b0, 4'b1110, mk_addr(10, 1), rand_w(), 4'd3);
        send_op(1'b0, 4'b1111, mk_addr(10, 1), rand_w(), 4'd7);

        // Empty mask: no request, one stall cycle.
        send_op(1'b0, 4'b0000, mk_addr(10, 1), rand_w(), 4'd2);

        // Back-to-back loads with op_valid held across the first writeback.
        drive_op(1'b0, 4'b1111, mk_addr(10, 1), rand_w(), 4'd5);
        drive_op(1'b0, 4'b0101, mk_addr(10, 2), rand_w(), 4'd6);
        n = 0;
        do begin @(negedge clk); n++; end while (!bus.wb_valid && n < 100);
        check("b2b_first_wb", W'(bus.wb_valid), W'(1));
        @(posedge clk);
        @(posedge clk); #1;
        release_op();
        wait_idle();

        // Reset while the controller is busy (FSM in WAIT_DONE).
        force_mode = 3;
        drive_op(1'b0, 4'b1011, mk_addr(11, 1), rand_w(), 4'd9);
        @(posedge clk); #1;
        release_op();
        n = 0;
        do begin @(negedge clk); n++; end while (!bus.MRead && n < 10);
        check("rst_test_issue", W'(bus.MRead), W'(1));
        repeat (2) @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        check_all_zero("midrst");
        void'(wb_q.pop_back());
        repeat (2) @(negedge clk);
        @(posedge clk); #1;
        reset = 1'b1;
        force_mode = 0;
        send_op(1'b0, 4'b1111, mk_addr(10, 1), rand_w(), 4'd4);

        for (int k = 0; k < 40; k++) begin
            logic               rwr;
            logic [N_CORES-1:0] ren;
            rwr = 1'($urandom_range(0, 1));
            ren = ($urandom_range(0, 7) == 0) ? '0 : N_CORES'($urandom_range(1, 15));
            send_op(rwr, ren, mk_addr(int'($urandom_range(0, 40)), int'($urandom_range(1, 3))),
                    rand_w(), RD_W'($urandom_range(0, 15)));
            repeat ($urandom_range(0, 2)) @(posedge clk);
        end

`ifdef MEM_TIMEOUT_EN
        // Controller never answers: timeout_err after TIMEOUT_CYCLES waiting cycles.
        force_mode = 4;
        drive_op(1'b0, 4'b1111, mk_addr(10, 1), rand_w(), 4'd1);
        @(posedge clk); #1;
        release_op();
        n = 0;
        do begin @(negedge clk); n++; end while (!bus.MRead && n < 10);
        check("to_issue", W'(bus.MRead), W'(1));
        n = 0;
        do begin @(negedge clk); n++; end while (!bus.timeout_err && n < TIMEOUT_CYCLES + 50);
        check("to_cycle", W'(n), W'(TIMEOUT_CYCLES + 1));
        check("to_err", W'(bus.timeout_err), W'(1));
        check("to_stall", W'(bus.stall), '0);
        void'(wb_q.pop_back());
        repeat (3) @(negedge clk);
        check("to_sticky", W'(bus.timeout_err), W'(1));
        #2;
        reset = 1'b0;
        #1;
        check("to_cleared", W'(bus.timeout_err), '0);
        @(posedge clk); #1;
        reset = 1'b1;
        force_mode = 0;
`else
        check("no_timeout_err", W'(bus.timeout_err), '0);
`endif

        repeat (3) @(negedge clk);
        check("req_q_drained", W'(req_q.size()), '0);
        check("wb_q_drained", W'(wb_q.size()), '0);
        check("mread_count", W'(mread_cnt), W'(exp_loads));
        check("mwrite_count", W'(mwrite_cnt), W'(exp_stores));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
